// File: rtl/ci_master.sv
// Initiator for the multi-cycle custom-instruction slave interface.
// Optional watchdog abort in WAIT enabled by defining CI_MASTER_TIMEOUT_EN.
module ci_master #(
    parameter int DATA_W         = 32,
    parameter int N_W            = 8,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_dataa,
    input  logic [DATA_W-1:0] req_datab,
    input  logic [N_W-1:0]    req_n,
    output logic              ci_clk_en,
    output logic              ci_start,
    output logic [DATA_W-1:0] ci_dataa,
    output logic [DATA_W-1:0] ci_datab,
    output logic [N_W-1:0]    ci_n,
    input  logic              ci_done,
    input  logic [DATA_W-1:0] ci_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_timeout,
    output logic              busy,
    output logic [CNT_W-1:0]  op_count
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t state;
    state_t state_nx;

    logic accept;
    logic active;
    logic capture;
    logic abort;
    logic expired;
    logic release_rsp;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign ci_start  = (state == ISSUE);
    assign ci_clk_en = active;

    assign active      = (state == ISSUE) || (state == WAIT);
    assign accept      = (state == IDLE) && req_valid;
    assign release_rsp = (state == RESP) && rsp_valid && rsp_ready;

`ifdef CI_MASTER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [WD_W-1:0] wdog;

    // wdog holds the number of active cycles already completed,
    // so the limit is hit during the TIMEOUT_CYCLES-th active cycle.
    assign expired = (wdog == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wdog        <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            if (accept) begin
                wdog <= '0;
            end else if (active && !expired) begin
                wdog <= wdog + WD_W'(1);
            end
            if (capture || release_rsp) begin
                rsp_timeout <= 1'b0;
            end else if (abort) begin
                rsp_timeout <= 1'b1;
            end
        end
    end
`else
    assign expired     = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        capture  = 1'b0;
        abort    = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nx = ISSUE;
                end
            end
            ISSUE, WAIT: begin
                if (ci_done) begin
                    capture  = 1'b1;
                    state_nx = RESP;
                end else if (expired) begin
                    abort    = 1'b1;
                    state_nx = RESP;
                end else begin
                    state_nx = WAIT;
                end
            end
            RESP: begin
                if (rsp_valid && rsp_ready) begin
                    state_nx = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ci_dataa <= '0;
            ci_datab <= '0;
            ci_n     <= '0;
        end else if (accept) begin
            ci_dataa <= req_dataa;
            ci_datab <= req_datab;
            ci_n     <= req_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            op_count   <= '0;
        end else begin
            if (capture) begin
                rsp_valid  <= 1'b1;
                rsp_result <= ci_result;
                op_count   <= op_count + CNT_W'(1);
            end else if (abort) begin
                rsp_valid  <= 1'b1;
                rsp_result <= '1;
            end else if (release_rsp) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ci_master.sv
// Directed bench for ci_master with a cycle-counting slave stub.
module tb_ci_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n   = 1'b0;
    logic        req_valid = 1'b0;
    logic        rsp_ready = 1'b0;
    logic        sp_done   = 1'b0;
    logic        sl_en     = 1'b1;
    logic [31:0] req_dataa = '0;
    logic [31:0] req_datab = '0;
    logic [31:0] sl_result = '0;
    logic [7:0]  req_n     = '0;
    int          sl_k      = 0;

    logic        req_ready, ci_clk_en, ci_start, ci_done;
    logic [31:0] ci_dataa, ci_datab, ci_result, rsp_result;
    logic [7:0]  ci_n;
    logic        rsp_valid, rsp_timeout, busy;
    logic [15:0] op_count;

    logic        s_req_ready, s_ci_clk_en, s_ci_start;
    logic [31:0] s_ci_dataa, s_ci_datab, s_rsp_result;
    logic [7:0]  s_ci_n;
    logic        s_rsp_valid, s_rsp_timeout, s_busy;
    logic [3:0]  s_op_count;

    int n_checks = 0;
    int n_errors = 0;

    // slave stub: done k cycles after the start cycle (k=0 is combinational)
    logic sl_act = 1'b0;
    int   sl_cnt = 0;
    always @(posedge clk) begin
        if (ci_done) begin
            sl_act <= 1'b0;
        end else if (ci_start) begin
            sl_act <= 1'b1;
            sl_cnt <= 1;
        end else if (sl_act) begin
            sl_cnt <= sl_cnt + 1;
        end
    end
    assign ci_done = sp_done | (sl_en && ((sl_k == 0 && ci_start) ||
                                          (sl_act && sl_cnt == sl_k)));
    assign ci_result = sl_result;

    ci_master #(.DATA_W(32), .N_W(8), .CNT_W(16), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dataa(req_dataa), .req_datab(req_datab), .req_n(req_n),
        .ci_clk_en(ci_clk_en), .ci_start(ci_start),
        .ci_dataa(ci_dataa), .ci_datab(ci_datab), .ci_n(ci_n),
        .ci_done(ci_done), .ci_result(ci_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_timeout(rsp_timeout),
        .busy(busy), .op_count(op_count)
    );

    // narrow-counter copy in lockstep, used to reach the wrap point quickly
    ci_master #(.DATA_W(32), .N_W(8), .CNT_W(4), .TIMEOUT_CYCLES(16)) dut_s (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(s_req_ready),
        .req_dataa(req_dataa), .req_datab(req_datab), .req_n(req_n),
        .ci_clk_en(s_ci_clk_en), .ci_start(s_ci_start),
        .ci_dataa(s_ci_dataa), .ci_datab(s_ci_datab), .ci_n(s_ci_n),
        .ci_done(ci_done), .ci_result(ci_result),
        .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(s_rsp_result), .rsp_timeout(s_rsp_timeout),
        .busy(s_busy), .op_count(s_op_count)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset;
        reset_n   = 1'b0;
        req_valid = 1'b1;
        tick();
        tick();
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_req_ready: got %b want 1", req_ready);
        end
        n_checks++;
        if ({busy, ci_start, ci_clk_en, rsp_valid, rsp_timeout} !== 5'b0) begin
            n_errors++;
            $display("FAIL reset_flags: got %b want 00000",
                     {busy, ci_start, ci_clk_en, rsp_valid, rsp_timeout});
        end
        n_checks++;
        if (op_count !== 16'h0 || rsp_result !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_regs: got cnt %h res %h want 0 0",
                     op_count, rsp_result);
        end
        n_checks++;
        if (ci_dataa !== 32'h0 || ci_datab !== 32'h0 || ci_n !== 8'h0) begin
            n_errors++;
            $display("FAIL reset_operands: got %h %h %h want 0",
                     ci_dataa, ci_datab, ci_n);
        end
        req_valid = 1'b0;
        reset_n   = 1'b1;
        tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_release_idle: got busy %b want 0", busy);
        end
    endtask

    task automatic test_single;
        int edges;
        int starts;
        bit hold_bad;
        edges = 0;
        starts = 0;
        hold_bad = 1'b0;
        sl_k = 3;
        sl_en = 1'b1;
        sl_result = 32'h4039A5E0;
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_dataa = 32'h3F0B851F;
        req_datab = 32'h40AA60FE;
        req_n = 8'h21;
        tick();
        edges = 1;
        req_valid = 1'b0;
        req_dataa = 32'hFFFFFFFF;
        req_datab = 32'h0;
        req_n = 8'h0;
        n_checks++;
        if ({ci_start, ci_clk_en, req_ready, busy} !== 4'b1101 ||
            ci_n !== 8'h21) begin
            n_errors++;
            $display("FAIL single_issue: got st/en/rdy/busy %b n %h want 1101 21",
                     {ci_start, ci_clk_en, req_ready, busy}, ci_n);
        end
        while (edges < 20 && !rsp_valid) begin
            if (ci_start) starts++;
            if (ci_dataa !== 32'h3F0B851F || ci_datab !== 32'h40AA60FE)
                hold_bad = 1'b1;
            tick();
            edges++;
        end
        n_checks++;
        if (edges !== 5) begin
            n_errors++;
            $display("FAIL single_latency: got %0d edges want 5", edges);
        end
        n_checks++;
        if (starts !== 1 || hold_bad !== 1'b0) begin
            n_errors++;
            $display("FAIL single_start_hold: got starts %0d hold_bad %b want 1 0",
                     starts, hold_bad);
        end
        n_checks++;
        if (rsp_result !== 32'h4039A5E0 || rsp_timeout !== 1'b0) begin
            n_errors++;
            $display("FAIL single_result: got %h to %b want 4039a5e0 0",
                     rsp_result, rsp_timeout);
        end
        n_checks++;
        if (op_count !== 16'd1 || ci_clk_en !== 1'b0) begin
            n_errors++;
            $display("FAIL single_count: got cnt %0d en %b want 1 0",
                     op_count, ci_clk_en);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL single_release: got busy %b valid %b want 0 0",
                     busy, rsp_valid);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] va [4];
        logic [31:0] vb [4];
        logic [31:0] vr [4];
        va = '{32'h3F800000, 32'h40000000, 32'hC0490FDB, 32'h00000001};
        vb = '{32'h40400000, 32'h3F000000, 32'h3DCCCCCD, 32'h7F7FFFFF};
        vr = '{32'h40800000, 32'h3F800000, 32'hBF800000, 32'h80000000};
        do_reset();
        sl_k = 0;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_dataa = va[0];
        req_datab = vb[0];
        sl_result = vr[0];
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (ci_start !== 1'b1 || req_ready !== 1'b0 ||
                ci_dataa !== va[i] || ci_datab !== vb[i]) begin
                n_errors++;
                $display("FAIL b2b_issue%0d: got st %b rdy %b a %h b %h want 1 0 %h %h",
                         i, ci_start, req_ready, ci_dataa, ci_datab, va[i], vb[i]);
            end
            if (i < 3) begin
                req_dataa = va[i+1];
                req_datab = vb[i+1];
            end else begin
                req_valid = 1'b0;
            end
            tick();
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_result !== vr[i] || req_ready !== 1'b0) begin
                n_errors++;
                $display("FAIL b2b_rsp%0d: got v %b res %h rdy %b want 1 %h 0",
                         i, rsp_valid, rsp_result, req_ready, vr[i]);
            end
            if (i < 3) sl_result = vr[i+1];
            tick();
            n_checks++;
            if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL b2b_idle%0d: got rdy %b v %b want 1 0",
                         i, req_ready, rsp_valid);
            end
        end
        n_checks++;
        if (op_count !== 16'd4) begin
            n_errors++;
            $display("FAIL b2b_count: got %0d want 4", op_count);
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        int edges;
        edges = 0;
        sl_k = 1;
        sl_result = 32'h12345678;
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_dataa = 32'h11111111;
        req_datab = 32'h22222222;
        tick();
        req_valid = 1'b0;
        while (edges < 20 && !rsp_valid) begin
            tick();
            edges++;
        end
        for (int c = 0; c < 10; c++) begin
            sp_done = (c % 2 == 0);
            sl_result = 32'hDEAD0000 | c;
            req_valid = 1'b1;
            req_dataa = 32'hCAFE0000 | c;
            tick();
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_result !== 32'h12345678 ||
                req_ready !== 1'b0 || ci_dataa !== 32'h11111111) begin
                n_errors++;
                $display("FAIL bp_hold%0d: got v %b res %h rdy %b a %h want 1 12345678 0 11111111",
                         c, rsp_valid, rsp_result, req_ready, ci_dataa);
            end
        end
        sp_done = 1'b0;
        req_valid = 1'b0;
        n_checks++;
        if (op_count !== 16'd5) begin
            n_errors++;
            $display("FAIL bp_count: got %0d want 5", op_count);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_release: got busy %b v %b want 0 0", busy, rsp_valid);
        end
        sp_done = 1'b1;
        tick();
        sp_done = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || op_count !== 16'd5) begin
            n_errors++;
            $display("FAIL idle_done_ignored: got busy %b v %b cnt %0d want 0 0 5",
                     busy, rsp_valid, op_count);
        end
    endtask

    task automatic test_reset_mid_wait;
        bit bad;
        bad = 1'b0;
        sl_k = 5;
        sl_result = 32'hAAAA5555;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        n_checks++;
        if (busy !== 1'b1 || ci_clk_en !== 1'b1 || ci_start !== 1'b0) begin
            n_errors++;
            $display("FAIL rmw_in_wait: got busy %b en %b st %b want 1 1 0",
                     busy, ci_clk_en, ci_start);
        end
        do_reset();
        n_checks++;
        if (busy !== 1'b0 || ci_clk_en !== 1'b0 || rsp_valid !== 1'b0 ||
            op_count !== 16'd0 || req_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL rmw_after_reset: got busy %b en %b v %b cnt %0d rdy %b want 0 0 0 0 1",
                     busy, ci_clk_en, rsp_valid, op_count, req_ready);
        end
        for (int c = 0; c < 6; c++) begin
            tick();
            if (busy !== 1'b0 || rsp_valid !== 1'b0 || op_count !== 16'd0)
                bad = 1'b1;
        end
        n_checks++;
        if (bad !== 1'b0) begin
            n_errors++;
            $display("FAIL rmw_late_done: got disturbed %b want 0", bad);
        end
    endtask

    task automatic test_wrap;
        do_reset();
        sl_k = 0;
        sl_result = 32'h0BADF00D;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            if (i == 17) begin
                tick();
                req_valid = 1'b0;
                tick();
                tick();
            end else begin
                tick();
                tick();
                tick();
            end
            if (i == 15) begin
                n_checks++;
                if (s_op_count !== 4'hF) begin
                    n_errors++;
                    $display("FAIL wrap_max: got %h want f", s_op_count);
                end
            end else if (i == 16) begin
                n_checks++;
                if (s_op_count !== 4'h0) begin
                    n_errors++;
                    $display("FAIL wrap_zero: got %h want 0", s_op_count);
                end
            end else if (i == 17) begin
                n_checks++;
                if (s_op_count !== 4'h1) begin
                    n_errors++;
                    $display("FAIL wrap_one: got %h want 1", s_op_count);
                end
            end
        end
        n_checks++;
        if (op_count !== 16'd17 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL wrap_wide: got cnt %0d busy %b want 17 0", op_count, busy);
        end
        rsp_ready = 1'b0;
    endtask

`ifdef CI_MASTER_TIMEOUT_EN
    task automatic test_timeout;
        int edges;
        do_reset();
        sl_en = 1'b0;
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        edges = 1;
        while (edges < 40 && !rsp_valid) begin
            tick();
            edges++;
        end
        n_checks++;
        if (edges !== 17 || rsp_result !== 32'hFFFFFFFF ||
            rsp_timeout !== 1'b1 || op_count !== 16'd0) begin
            n_errors++;
            $display("FAIL timeout_abort: got edges %0d res %h to %b cnt %0d want 17 ffffffff 1 0",
                     edges, rsp_result, rsp_timeout, op_count);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        sl_en = 1'b1;
        sl_k = 15;
        sl_result = 32'h3F800000;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        edges = 1;
        while (edges < 40 && !rsp_valid) begin
            tick();
            edges++;
        end
        n_checks++;
        if (edges !== 17 || rsp_result !== 32'h3F800000 ||
            rsp_timeout !== 1'b0 || op_count !== 16'd1) begin
            n_errors++;
            $display("FAIL timeout_done_wins: got edges %0d res %h to %b cnt %0d want 17 3f800000 0 1",
                     edges, rsp_result, rsp_timeout, op_count);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_wait();
        test_wrap();
`ifdef CI_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
